// File: rtl/slow_meter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : slow_meter
// Description : Measures a slow square wave that is asynchronous to CLOCK.
//               SLOW_IN is synchronised, and its rising edges are detected.
//               The block reports the rising-to-rising interval (PERIOD) and
//               the number of cycles the input was high in that interval
//               (HIGH_TIME), both counted in CLOCK cycles.
// Ports       : CLOCK      - single clock, rising edge
//               RESET      - asynchronous, active-high reset
//               SLOW_IN    - signal under measurement (asynchronous)
//               ENABLE     - measurement enable (synchronous)
//               PERIOD     - last measured interval, WIDTH bits
//               HIGH_TIME  - high cycles within that interval, WIDTH bits
//               VALID      - one-cycle pulse when PERIOD/HIGH_TIME update
//               TIMEOUT    - sticky: no rising edge within 2^WIDTH-1 cycles
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module slow_meter #(
    parameter int WIDTH       = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             SLOW_IN,
    input  logic             ENABLE,
    output logic [WIDTH-1:0] PERIOD,
    output logic [WIDTH-1:0] HIGH_TIME,
    output logic             VALID,
    output logic             TIMEOUT
);

    localparam logic [WIDTH-1:0] c_cnt_max = '1;
    localparam logic [WIDTH-1:0] c_one     = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [WIDTH-1:0]       r_cnt;
    logic [WIDTH-1:0]       r_hcnt;

    logic                   w_s;
    logic                   w_edge;

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_edge = w_s & ~r_prev;

    // Synchroniser and edge-history flop run regardless of ENABLE so that an
    // edge can be recognised on the very first enabled cycle.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], SLOW_IN};
            r_prev <= w_s;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_hcnt    <= '0;
            PERIOD    <= '0;
            HIGH_TIME <= '0;
            VALID     <= 1'b0;
            TIMEOUT   <= 1'b0;
        end else begin
            VALID <= 1'b0;
            // Disable overrides everything, including an edge this cycle.
            if (!ENABLE) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_hcnt  <= '0;
                TIMEOUT <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_cnt   <= '0;
                        r_hcnt  <= '0;
                        r_state <= ST_ARM;
                    end
                    ST_ARM: begin
                        // First edge only opens the interval; nothing to report.
                        if (w_edge) begin
                            r_cnt   <= c_one;
                            r_hcnt  <= c_one;
                            r_state <= ST_MEASURE;
                        end
                    end
                    ST_MEASURE: begin
                        // The edge cycle itself starts the next interval, and
                        // S is high on it, so both counts restart at one.
                        if (w_edge) begin
                            PERIOD    <= r_cnt;
                            HIGH_TIME <= r_hcnt;
                            VALID     <= 1'b1;
                            TIMEOUT   <= 1'b0;
                            r_cnt     <= c_one;
                            r_hcnt    <= c_one;
                        end else if (r_cnt == c_cnt_max) begin
                            TIMEOUT <= 1'b1;
                            r_cnt   <= '0;
                            r_hcnt  <= '0;
                            r_state <= ST_ARM;
                        end else begin
                            r_cnt <= r_cnt + c_one;
                            // HCNT only advances alongside CNT, so it can never
                            // exceed CNT and never wraps.
                            if (w_s) begin
                                r_hcnt <= r_hcnt + c_one;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_slow_meter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_slow_meter
// Description : Self-checking bench for slow_meter (WIDTH=8, SYNC_STAGES=2).
//               Reference model works on edge timestamps and a running count
//               of high cycles rather than on counters.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_slow_meter;

    localparam int WIDTH = 8;
    localparam int SS    = 2;
    localparam int MAXC  = (1 << WIDTH) - 1;

    logic             CLOCK   = 1'b0;
    logic             RESET   = 1'b1;
    logic             SLOW_IN = 1'b0;
    logic             ENABLE  = 1'b0;
    logic [WIDTH-1:0] PERIOD;
    logic [WIDTH-1:0] HIGH_TIME;
    logic             VALID;
    logic             TIMEOUT;

    slow_meter #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SS)
    ) u_dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .SLOW_IN   (SLOW_IN),
        .ENABLE    (ENABLE),
        .PERIOD    (PERIOD),
        .HIGH_TIME (HIGH_TIME),
        .VALID     (VALID),
        .TIMEOUT   (TIMEOUT)
    );

    always #5 CLOCK = ~CLOCK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_mode;        // 0 idle, 1 waiting for first edge, 2 measuring
    int m_period;
    int m_high;
    bit m_valid;
    bit m_tout;
    bit h[SS+1];       // h[0] = most recently sampled input
    int cyc     = 0;   // clock edges modelled so far
    int t0      = 0;   // cycle of last reference edge
    int ones    = 0;   // synchronised-high cycles before cyc
    int ones_t0 = 0;   // value of ones at t0
    int en_off  = 0;
    bit allow_drop = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode   = 0;
        m_period = 0;
        m_high   = 0;
        m_valid  = 1'b0;
        m_tout   = 1'b0;
        for (int i = 0; i <= SS; i++) h[i] = 1'b0;
    endtask

    // Effect of the coming clock edge, given the inputs it will sample.
    task automatic model_step(input bit en, input bit sin);
        bit sv, pv, d;
        int el;
        sv = h[SS-1];
        pv = h[SS];
        d  = sv && !pv;
        el = cyc - t0;
        m_valid = 1'b0;
        if (!en) begin
            m_mode = 0;
            m_tout = 1'b0;
        end else begin
            case (m_mode)
                0: m_mode = 1;
                1: if (d) begin
                       m_mode = 2; t0 = cyc; ones_t0 = ones;
                   end
                default: begin
                    if (d) begin
                        m_period = el;
                        m_high   = ones - ones_t0;
                        m_valid  = 1'b1;
                        m_tout   = 1'b0;
                        t0 = cyc; ones_t0 = ones;
                    end else if (el == MAXC) begin
                        m_tout = 1'b1;
                        m_mode = 1;
                    end
                end
            endcase
        end
        ones += int'(sv);
        cyc++;
        for (int i = SS; i > 0; i--) h[i] = h[i-1];
        h[0] = sin;
    endtask

    task automatic check_outputs();
        check_val("period",    PERIOD,    m_period);
        check_val("high_time", HIGH_TIME, m_high);
        check_val("valid",     VALID,     m_valid);
        check_val("timeout",   TIMEOUT,   m_tout);
    endtask

    task automatic tick(input bit sin);
        @(negedge CLOCK);
        check_outputs();
        SLOW_IN = sin;
        if (en_off > 0) begin
            ENABLE = 1'b0;
            en_off--;
        end else begin
            ENABLE = 1'b1;
            if (allow_drop && $urandom_range(0, 59) == 0)
                en_off = $urandom_range(1, 4);
        end
        model_step(ENABLE, sin);
    endtask

    task automatic wave(input int p, input int hi, input int n);
        for (int k = 0; k < n; k++)
            for (int j = 0; j < p; j++)
                tick(j < hi);
    endtask

    task automatic reset_zero_check();
        check_val("rst_period",    PERIOD,    0);
        check_val("rst_high_time", HIGH_TIME, 0);
        check_val("rst_valid",     VALID,     0);
        check_val("rst_timeout",   TIMEOUT,   0);
    endtask

    // Asynchronous reset pulse between edges, held across one edge.
    task automatic do_reset();
        @(negedge CLOCK);
        check_outputs();
        SLOW_IN = 1'($urandom);
        #2 RESET = 1'b1;
        #1 reset_zero_check();
        model_reset();
        @(negedge CLOCK);
        reset_zero_check();
        RESET   = 1'b0;
        SLOW_IN = 1'b0;
        ENABLE  = 1'b1;
        en_off  = 0;
        model_step(ENABLE, SLOW_IN);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge CLOCK);
        reset_zero_check();
        RESET  = 1'b0;
        ENABLE = 1'b1;
        model_step(ENABLE, SLOW_IN);

        // Directed: basic period-10 stream, fast toggle, timeout then recovery
        wave(10, 4, 5);
        wave(2, 1, 10);
        wave(1, 1, 1);
        for (int i = 0; i < 300; i++) tick(1'b0);
        wave(20, 7, 3);

        // Enable low for 3 cycles inside a period-10 stream
        wave(10, 4, 2);
        en_off = 3;
        wave(10, 4, 4);

        // Reset in the middle of a period
        for (int j = 0; j < 5; j++) tick(j < 4);
        do_reset();
        wave(10, 4, 4);

        // Saturation boundary: exactly max, and one beyond
        wave(255, 1, 3);
        wave(256, 3, 3);
        wave(254, 200, 2);

        // Randomised segments
        for (int seg = 0; seg < 40; seg++) begin
            int kind, p, hi;
            kind = $urandom_range(0, 9);
            if (kind <= 5) begin
                p  = $urandom_range(2, 40);
                hi = $urandom_range(1, p - 1);
                allow_drop = 1'b1;
                wave(p, hi, $urandom_range(2, 5));
                allow_drop = 1'b0;
            end else if (kind == 6) begin
                wave(2, 1, $urandom_range(3, 12));
            end else if (kind == 7) begin
                for (int i = 0; i < 260; i++) tick(1'b0);
            end else if (kind == 8) begin
                do_reset();
            end else begin
                for (int i = 0; i < 30; i++) tick(1'($urandom));
            end
        end

        @(negedge CLOCK);
        check_outputs();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/slow_meter.md
SLOW_METER -- requirements
Module: slow_meter

Interface
REQ-001 SHALL have parameter WIDTH, default 24, bit width of period/high-time counters and outputs.
REQ-002 SHALL have parameter SYNC_STAGES, default 2 (min 2), number of synchronizer flops on SLOW_IN.
REQ-003 SHALL have port CLOCK  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port SLOW_IN  input  1  divided/slow square wave under measurement; asynchronous to CLOCK.
REQ-006 SHALL have port ENABLE  input  1  measurement enable, synchronous to CLOCK.
REQ-007 SHALL have port PERIOD  output  WIDTH  last measured rising-to-rising interval, in CLOCK cycles.
REQ-008 SHALL have port HIGH_TIME  output  WIDTH  CLOCK cycles SLOW_IN was high within that interval.
REQ-009 SHALL have port VALID  output  1  one-cycle pulse: PERIOD/HIGH_TIME just updated.
REQ-010 SHALL have port TIMEOUT  output  1  sticky flag: no rising edge within 2^WIDTH-1 cycles.

Function
REQ-011 SHALL pass SLOW_IN through SYNC_STAGES flops (S) plus one delay flop (P); rising edge detect D = S & ~P, combinational.
REQ-012 SHALL implement states IDLE, ARM, MEASURE, with an internal WIDTH-bit period count CNT and high count HCNT.
REQ-013 IDLE: CNT=0, HCNT=0; ENABLE=1 -> ARM next cycle.
REQ-014 ARM: on D=1 -> CNT<=1, HCNT<=1, MEASURE; no VALID for this first edge.
REQ-015 MEASURE, D=0, CNT<2^WIDTH-1: CNT<=CNT+1; HCNT<=HCNT+1 when S=1, else hold.
REQ-016 MEASURE, D=1: PERIOD<=CNT, HIGH_TIME<=HCNT, VALID<=1, TIMEOUT<=0, CNT<=1, HCNT<=1, stay MEASURE.
REQ-017 MEASURE, D=0, CNT==2^WIDTH-1: TIMEOUT<=1, -> ARM; PERIOD/HIGH_TIME held, no VALID.
REQ-018 Edge and saturation in the same cycle: edge wins (REQ-016), measurement of 2^WIDTH-1 reported.
REQ-019 ENABLE=0 in any state: -> IDLE next cycle, CNT/HCNT cleared, VALID=0, TIMEOUT cleared; PERIOD/HIGH_TIME hold.
REQ-020 ENABLE=0 has priority over an edge detected in the same cycle (no VALID).
REQ-021 VALID SHALL be high for exactly one cycle per measured edge, registered, coincident with the updated PERIOD/HIGH_TIME.
REQ-022 Latency: VALID SHALL rise on the (SYNC_STAGES+1)th CLOCK edge counting the first edge that samples SLOW_IN=1.
REQ-023 PERIOD SHALL equal the cycle distance between successive D=1 cycles; HIGH_TIME <= PERIOD always; no wrap of CNT or HCNT.
REQ-024 Minimum measurable PERIOD SHALL be 2 (SLOW_IN toggling every CLOCK cycle).
REQ-025 Synchronizer and P flops SHALL run in all states so edge detection is valid immediately on ENABLE.

Reset
REQ-026 RESET=1 SHALL asynchronously force state IDLE, CNT=0, HCNT=0, synchronizer and P flops 0, PERIOD=0, HIGH_TIME=0, VALID=0, TIMEOUT=0.
REQ-027 After RESET release, first VALID SHALL require two detected rising edges; reset mid-measurement discards the partial count.

Verification
REQ-028 WIDTH=24, ENABLE=1, SLOW_IN period 10 (high 4, low 6) -> first edge no VALID; each later edge VALID pulse, PERIOD=10, HIGH_TIME=4.
REQ-029 SLOW_IN toggling every cycle -> PERIOD=2, HIGH_TIME=1, VALID every 2 cycles.
REQ-030 WIDTH=8, one edge then SLOW_IN held 0 -> TIMEOUT=1 after 255 cycles, no VALID, PERIOD unchanged; next two edges 20 apart -> VALID, PERIOD=20, TIMEOUT=0.
REQ-031 RESET pulsed mid-period (CNT~5) with period-10 input -> all outputs 0 immediately; first VALID on second post-reset edge with PERIOD=10.
REQ-032 ENABLE dropped for 3 cycles during period-10 stream -> no VALID while low or on first edge after re-enable; PERIOD holds 10 throughout.
REQ-033 Single rising edge at SYNC_STAGES=2: VALID rises on 3rd CLOCK edge counting the first sampling SLOW_IN=1.
